// File: rtl/mul8_pkg.sv
// Shared types and sizing for the 32x32 partial-product dispatcher.
// Holds the dispatcher state encoding and the per-lane shift helper.
package mul8_pkg;

  localparam int unsigned LANES   = 8;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned OP_W    = 32;
  localparam int unsigned SHIFT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_ISSUE1,
    ST_WAIT_ACC
  } state_e;

  // Lane k multiplies A byte (k mod 4) by B byte row; phase 1 moves to rows 2..3.
  function automatic logic [SHIFT_W-1:0] lane_shift(input int unsigned lane, input logic phase);
    int unsigned row;
    row = (lane / 4) + (phase ? 2 : 0);
    return SHIFT_W'(((lane % 4) + row) * BYTE_W);
  endfunction

endpackage

// File: rtl/byte_lane_sel.sv
// Pure bit-slicing byte selector: picks byte idx out of a 32-bit word.
module byte_lane_sel
  import mul8_pkg::*;
(
  input  logic [OP_W-1:0]   word,
  input  logic [1:0]        idx,
  output logic [BYTE_W-1:0] sel_byte
);

  always_comb begin
    sel_byte = '0;
    unique case (idx)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = '0;
    endcase
  end

endmodule

// File: rtl/pp_dispatcher_8.sv
// Dispatches a 32x32 operand pair as sixteen 8x8 partial products over two
// cycles on eight multiplier lanes, then waits for the accumulator to finish.
module pp_dispatcher_8
  import mul8_pkg::*;
#(
  parameter int unsigned ACC_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [OP_W-1:0]    op_a,
  input  logic [OP_W-1:0]    op_b,
  input  logic               flush,
  input  logic               acc_done,
  output logic [BYTE_W-1:0]  mult_a   [0:LANES-1],
  output logic [BYTE_W-1:0]  mult_b   [0:LANES-1],
  output logic [SHIFT_W-1:0] pp_shift [0:LANES-1],
  output logic               start,
  output logic               pp_phase,
  output logic               busy,
  output logic               err_timeout
);

  localparam int unsigned CNT_W = (ACC_TIMEOUT > 2) ? $clog2(ACC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                issue_d, phase_d;

  logic [BYTE_W-1:0]   a_byte   [0:LANES-1];
  logic [BYTE_W-1:0]   b_byte   [0:LANES-1];
  logic [1:0]          b_idx    [0:LANES-1];

  logic [BYTE_W-1:0]   mult_a_q   [0:LANES-1];
  logic [BYTE_W-1:0]   mult_a_d   [0:LANES-1];
  logic [BYTE_W-1:0]   mult_b_q   [0:LANES-1];
  logic [BYTE_W-1:0]   mult_b_d   [0:LANES-1];
  logic [SHIFT_W-1:0]  pp_shift_q [0:LANES-1];
  logic [SHIFT_W-1:0]  pp_shift_d [0:LANES-1];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = '0;
    err_timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          state_d = ST_ISSUE0;
          a_d     = op_a;
          b_d     = op_b;
        end
      end
      ST_ISSUE0: state_d = ST_ISSUE1;
      ST_ISSUE1: state_d = ST_WAIT_ACC;
      ST_WAIT_ACC: begin
        if (acc_done) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          err_timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything decided above, including capture and the error pulse.
    if (flush) begin
      state_d     = ST_IDLE;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = '0;
      err_timeout = 1'b0;
    end
  end

  assign issue_d = (state_d == ST_ISSUE0) || (state_d == ST_ISSUE1);
  assign phase_d = (state_d == ST_ISSUE1);

  // Selectors look at the operand register's next value so lane data is
  // registered on the same edge that enters ISSUE0, including the capture edge.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      b_idx[k] = 2'(k / 4) + (phase_d ? 2'd2 : 2'd0);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    byte_lane_sel u_sel_a (.word(a_d), .idx(2'(k % 4)), .sel_byte(a_byte[k]));
    byte_lane_sel u_sel_b (.word(b_d), .idx(b_idx[k]),  .sel_byte(b_byte[k]));
  end

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      mult_a_d[k]   = issue_d ? a_byte[k] : '0;
      mult_b_d[k]   = issue_d ? b_byte[k] : '0;
      pp_shift_d[k] = issue_d ? lane_shift(k, phase_d) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        mult_a_q[k]   <= '0;
        mult_b_q[k]   <= '0;
        pp_shift_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      for (int unsigned k = 0; k < LANES; k++) begin
        mult_a_q[k]   <= mult_a_d[k];
        mult_b_q[k]   <= mult_b_d[k];
        pp_shift_q[k] <= pp_shift_d[k];
      end
    end
  end

  assign mult_a   = mult_a_q;
  assign mult_b   = mult_b_q;
  assign pp_shift = pp_shift_q;
  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign start    = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);
  assign pp_phase = (state_q == ST_ISSUE1);

endmodule

// File: tb/tb_pp_dispatcher_8.sv
// Self-checking bench for pp_dispatcher_8: directed scenarios plus random
// operations compared against a cycle-timeline reference model.
module tb_pp_dispatcher_8;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic        flush = 1'b0;
  logic        acc_done = 1'b0;
  logic [7:0]  mult_a   [0:7];
  logic [7:0]  mult_b   [0:7];
  logic [5:0]  pp_shift [0:7];
  logic        start, pp_phase, busy, err_timeout;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  pp_dispatcher_8 #(.ACC_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .flush(flush), .acc_done(acc_done),
    .mult_a(mult_a), .mult_b(mult_b), .pp_shift(pp_shift),
    .start(start), .pp_phase(pp_phase), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int unsigned i);
    logic [31:0] s;
    s = w >> (8 * i);
    return s[7:0];
  endfunction

  // Partial product PP(row,col) = A[col]*B[row], shifted by (row+col)*8.
  task automatic check_lanes(input string tag, input logic active, input logic [31:0] a,
                             input logic [31:0] b, input logic phase);
    for (int unsigned k = 0; k < 8; k++) begin
      int unsigned col, row;
      col = k % 4;
      row = k / 4 + (phase ? 2 : 0);
      chk($sformatf("%s.a%0d", tag, k), 64'(mult_a[k]),   active ? 64'(byte_of(a, col)) : 64'd0);
      chk($sformatf("%s.b%0d", tag, k), 64'(mult_b[k]),   active ? 64'(byte_of(b, row)) : 64'd0);
      chk($sformatf("%s.s%0d", tag, k), 64'(pp_shift[k]), active ? 64'((col + row) * 8) : 64'd0);
    end
    chk({tag, ".start"}, 64'(start),    64'(active));
    chk({tag, ".phase"}, 64'(pp_phase), 64'(active & phase));
  endtask

  task automatic check_idle(input string tag);
    check_lanes(tag, 1'b0, '0, '0, 1'b0);
    chk({tag, ".ready"}, 64'(op_ready),    64'd1);
    chk({tag, ".busy"},  64'(busy),        64'd0);
    chk({tag, ".err"},   64'(err_timeout), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE just after an edge. done_at: WAIT_ACC cycle index carrying
  // acc_done, negative for never. hold keeps op_valid high with other operands.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int done_at, input logic hold);
    op_valid = 1'b1; op_a = a; op_b = b; acc_done = 1'b0;
    tick();
    if (hold) begin
      op_a = ~a; op_b = a ^ b ^ 32'h5A5A_5A5A;
    end else begin
      op_valid = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      check_lanes($sformatf("%s.iss%0d", tag, c), 1'b1, a, b, c[0]);
      chk($sformatf("%s.iss%0d.busy", tag, c),  64'(busy),        64'd1);
      chk($sformatf("%s.iss%0d.ready", tag, c), 64'(op_ready),    64'd0);
      chk($sformatf("%s.iss%0d.err", tag, c),   64'(err_timeout), 64'd0);
      acc_done = 1'($urandom_range(0, 1));
      tick();
    end
    for (int w = 0; w < int'(T); w++) begin
      acc_done = (w == done_at);
      #1;
      if (w == 0) check_lanes({tag, ".wait"}, 1'b0, '0, '0, 1'b0);
      chk($sformatf("%s.w%0d.busy", tag, w),  64'(busy),     64'd1);
      chk($sformatf("%s.w%0d.ready", tag, w), 64'(op_ready), 64'd0);
      chk($sformatf("%s.w%0d.err", tag, w),   64'(err_timeout),
          64'((w == int'(T) - 1) && (w != done_at)));
      tick();
      acc_done = 1'b0;
      if (w == done_at) break;
    end
    chk({tag, ".end.ready"}, 64'(op_ready),    64'd1);
    chk({tag, ".end.busy"},  64'(busy),        64'd0);
    chk({tag, ".end.err"},   64'(err_timeout), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          d;

    #12;
    check_idle("rst");
    tick();
    reset = 1'b1;
    tick();
    check_idle("post_rst");

    run_op("basic", 32'h0403_0201, 32'h0807_0605, 2, 1'b0);
    op_valid = 1'b1; op_a = 32'h0403_0201; op_b = 32'h0807_0605;
    tick();
    op_valid = 1'b0;
    chk("v42.l0a", 64'(mult_a[0]), 64'h01);
    chk("v42.l0b", 64'(mult_b[0]), 64'h05);
    chk("v42.l3a", 64'(mult_a[3]), 64'h04);
    chk("v42.l3s", 64'(pp_shift[3]), 64'd24);
    chk("v42.l7b", 64'(mult_b[7]), 64'h06);
    chk("v42.l7s", 64'(pp_shift[7]), 64'd32);
    tick();
    chk("v42.p1.l0b", 64'(mult_b[0]), 64'h07);
    chk("v42.p1.l0s", 64'(pp_shift[0]), 64'd16);
    chk("v42.p1.l7b", 64'(mult_b[7]), 64'h08);
    chk("v42.p1.l7s", 64'(pp_shift[7]), 64'd48);
    chk("v42.p1.ph",  64'(pp_phase), 64'd1);
    tick();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;

    run_op("ee", 32'hEEEE_EEEE, 32'hEEEE_EEEE, 0, 1'b0);
    run_op("hold", 32'h1122_3344, 32'h5566_7788, 3, 1'b1);
    chk("hold.ready", 64'(op_ready), 64'd1);
    run_op("newop", ~32'h1122_3344, 32'h1122_3344 ^ 32'h5566_7788 ^ 32'h5A5A_5A5A, 1, 1'b0);
    run_op("tmo", 32'hDEAD_BEEF, 32'hCAFE_F00D, -1, 1'b0);
    run_op("tie", 32'h0F0F_0F0F, 32'hF0F0_F0F0, int'(T) - 1, 1'b0);

    op_valid = 1'b1; op_a = 32'hAAAA_5555; op_b = 32'h1234_5678;
    tick();
    op_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_idle("flush_iss1");
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("flush_iss1.c%0d.err", i), 64'(err_timeout), 64'd0);
      tick();
    end

    op_valid = 1'b1; flush = 1'b1; op_a = 32'h1357_9BDF; op_b = 32'h2468_ACE0;
    tick();
    flush = 1'b0; op_valid = 1'b0;
    check_idle("flush_hs");

    op_valid = 1'b1; op_a = 32'hFEDC_BA98; op_b = 32'h7654_3210;
    tick();
    op_valid = 1'b0;
    #1;
    reset = 1'b0;
    #2;
    check_idle("rst_iss0");
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      check_idle($sformatf("rst_iss0.c%0d", i));
      tick();
    end

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      d  = int'($urandom_range(0, T + 1));
      if (d >= int'(T)) d = -1;
      run_op($sformatf("rnd%0d", i), ra, rb, d, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pp_dispatcher_8.md
PP_DISPATCHER_8 -- requirements
Module: pp_dispatcher_8

Interface
REQ-001 clk  input  1  sole clock, rising-edge active.
REQ-002 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 op_valid  input  1  operand pair offered.
REQ-004 op_ready  output  1  dispatcher can accept an operand pair.
REQ-005 op_a, op_b  input  32 each  unsigned multiplicand and multiplier.
REQ-006 flush  input  1  synchronous abort of any operation in flight.
REQ-007 acc_done  input  1  one-cycle pulse from the accumulator: 64-bit product complete.
REQ-008 mult_a[0:7], mult_b[0:7]  output  8 each  byte operands for the eight 8x8 multiplier lanes.
REQ-009 pp_shift[0:7]  output  6 each  left-shift amount in bits for each lane product, (row+col)*8.
REQ-010 start  output  1  held high while lane data is valid (ISSUE0, ISSUE1).
REQ-011 pp_phase  output  1  0 = lanes carry PP[0..7], 1 = lanes carry PP[8..15].
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err_timeout  output  1  one-cycle pulse: acc_done not received in time.
REQ-014 Parameter ACC_TIMEOUT, default 8, is the maximum number of WAIT_ACC cycles.

Function
REQ-015 FSM states: IDLE, ISSUE0, ISSUE1, WAIT_ACC.
REQ-016 op_ready = 1 only in IDLE; the handshake completes when op_valid and op_ready are both 1 at a rising edge.
REQ-017 On handshake: op_a and op_b are captured into internal registers, and the FSM goes IDLE -> ISSUE0.
REQ-018 ISSUE0 lasts exactly one cycle, then the FSM goes to ISSUE1.
REQ-019 ISSUE1 lasts exactly one cycle, then the FSM goes to WAIT_ACC.
REQ-020 ISSUE0 lane mapping, for lane k: mult_a[k] = A byte (k mod 4); mult_b[k] = B byte (k div 4).
REQ-021 ISSUE1 lane mapping, for lane k: mult_a[k] = A byte (k mod 4); mult_b[k] = B byte (2 + k div 4).
REQ-022 pp_shift[k] = ((k mod 4) + row)*8, where row = k div 4 in ISSUE0 and row = 2 + k div 4 in ISSUE1.
REQ-023 All lane outputs are registered and change on the same edge that enters ISSUE0 or ISSUE1.
REQ-024 First lane data appears one cycle after the handshake edge.
REQ-025 Outside ISSUE0/ISSUE1: mult_a, mult_b, pp_shift and start are all 0; pp_phase = 0.
REQ-026 WAIT_ACC: a cycle counter starts at 0 on entry and increments each cycle.
REQ-027 WAIT_ACC exit: acc_done = 1 -> IDLE, and op_ready becomes 1 on the next cycle.
REQ-028 WAIT_ACC timeout: when the counter reaches ACC_TIMEOUT-1 without acc_done, err_timeout pulses for one cycle and the FSM goes to IDLE.
REQ-029 acc_done and the timeout in the same cycle: acc_done wins and no error pulse is issued.
REQ-030 acc_done is ignored outside WAIT_ACC.
REQ-031 flush = 1 in any state forces IDLE on the next edge and zeroes the lane outputs; flush wins over a handshake and over acc_done.
REQ-032 op_valid while busy is ignored; the offered operands are not captured and op_ready stays 0.
REQ-033 Back-to-back operation: a new handshake is possible on the cycle the FSM returns to IDLE.
REQ-034 Operands are unsigned.
REQ-035 No arithmetic is performed; byte extraction is pure bit slicing.

Reset
REQ-036 reset = 0 asynchronously forces: state IDLE, captured operands 0, counter 0, every output 0 except op_ready.
REQ-037 op_ready = 1 immediately after reset deasserts.
REQ-038 Reset during ISSUE0, ISSUE1 or WAIT_ACC abandons the operation; no err_timeout pulse is issued.

Structure
REQ-039 Shared package mul8_pkg holds: the state enum, LANES = 8, BYTE_W = 8, OP_W = 32, SHIFT_W = 6.
REQ-040 Byte selection uses one sub-module, byte_lane_sel: inputs = 32-bit word and 2-bit index; output = 8-bit byte.
REQ-041 byte_lane_sel is instantiated 16 times, 8 lanes x a/b.

Verification
REQ-042 op_a=0x04030201, op_b=0x08070605 accepted:
- cycle+1: lane0 = (01,05), shift 0; lane3 = (04,05), shift 24; lane7 = (04,06), shift 32; pp_phase = 0.
- cycle+2: lane0 = (01,07), shift 16; lane7 = (04,08), shift 48; pp_phase = 1.
REQ-043 op_a = op_b = 0xEEEEEEEE: all lanes = (EE,EE) in both phases; start = 1 for exactly 2 cycles.
REQ-044 op_valid held high during WAIT_ACC with different operands: op_ready = 0 and no capture; after acc_done, the next handshake takes the new operands.
REQ-045 No acc_done with ACC_TIMEOUT=8: err_timeout pulses 10 cycles after the handshake; op_ready = 1 the cycle after.
REQ-046 flush asserted in ISSUE1: lanes and start are 0 next cycle, state IDLE, no err_timeout.
REQ-047 reset pulled low in ISSUE0: all outputs 0 immediately without a clock edge; op_ready = 1 after release.
